// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: N_ALARM BCD mm:ss alarm slots, per-second match, lowest-index ring arbitration, snooze/timeout/minigame handshake.
// State and outputs update one cycle after their cause (rd_time is combinational); no backpressure, pulses act in the cycle they arrive.
module multi_alarm_ctrl #(
  parameter  int N_ALARM        = 4,
  parameter  int SNOOZE_MIN     = 5,
  parameter  int RING_TIMEOUT_S = 60,
  localparam int IDX_W          = $clog2(N_ALARM)
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               tick_1s,
  input  logic [15:0]        cur_time,
  input  logic               master_en,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [15:0]        wr_time,
  input  logic               wr_arm,
  input  logic               btn_enter,
  input  logic               btn_snooze,
  input  logic               game_done,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [15:0]        rd_time,
  output logic [N_ALARM-1:0] armed,
  output logic [N_ALARM-1:0] pending,
  output logic               ring,
  output logic [IDX_W-1:0]   ring_idx,
  output logic               game_start,
  output logic               game_en,
  output logic               wr_err
);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_GAME} state_t;

  state_t             r_state;
  logic [15:0]        r_time     [N_ALARM];
  logic [15:0]        r_snz_time [N_ALARM];
  logic [N_ALARM-1:0] r_armed;
  logic [N_ALARM-1:0] r_snoozed;
  logic [N_ALARM-1:0] r_pending;
  logic [IDX_W-1:0]   r_ring_idx;
  logic [7:0]         r_cnt;
  logic               r_ring;
  logic               r_game_en;
  logic               r_game_start;
  logic               r_wr_err;

  state_t             w_state_nxt;
  logic [15:0]        w_time_nxt     [N_ALARM];
  logic [15:0]        w_snz_time_nxt [N_ALARM];
  logic [N_ALARM-1:0] w_armed_nxt;
  logic [N_ALARM-1:0] w_snz_nxt;
  logic [N_ALARM-1:0] w_pend_nxt;
  logic [N_ALARM-1:0] w_match;
  logic [IDX_W-1:0]   w_ring_idx_nxt;
  logic [IDX_W-1:0]   w_low_idx;
  logic [7:0]         w_cnt_nxt;
  logic               w_start;
  logic               w_wr_ok;
  logic               w_hit_ring;
  logic [7:0]         w_ring_sec;
  logic [6:0]         w_min_bin;
  logic [6:0]         w_min_add;
  logic [6:0]         w_min_mod;
  logic [15:0]        w_snz_val;
  logic [15:0]        w_rd_time;

  assign w_wr_ok = wr_en && (wr_time[15:12] <= 4'd5) && (wr_time[11:8] <= 4'd9) &&
                   (wr_time[7:4] <= 4'd5) && (wr_time[3:0] <= 4'd9);
  assign w_hit_ring = w_wr_ok && (wr_idx == r_ring_idx) && (r_state != S_IDLE);

  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      w_match[i] = tick_1s & master_en & r_armed[i] &
                   ((r_snoozed[i] ? r_snz_time[i] : r_time[i]) == cur_time);
    end
  end

  // Snooze target: current minute plus SNOOZE_MIN in binary, wrapped at 60, back to BCD; seconds from the stored alarm.
  always_comb begin
    w_ring_sec = '0;
    w_rd_time  = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (r_ring_idx == IDX_W'(i)) w_ring_sec = r_time[i][7:0];
      if (rd_idx == IDX_W'(i))     w_rd_time  = r_time[i];
    end
    w_min_bin = 7'(cur_time[15:12]) * 7'd10 + 7'(cur_time[11:8]);
    w_min_add = w_min_bin + 7'(SNOOZE_MIN);
    w_min_mod = (w_min_add >= 7'd60) ? (w_min_add - 7'd60) : w_min_add;
    w_snz_val = {4'(w_min_mod / 7'd10), 4'(w_min_mod % 7'd10), w_ring_sec};
  end

  always_comb begin
    w_pend_nxt     = r_pending | w_match;
    w_snz_nxt      = r_snoozed;
    w_armed_nxt    = r_armed;
    w_time_nxt     = r_time;
    w_snz_time_nxt = r_snz_time;
    w_state_nxt    = r_state;
    w_ring_idx_nxt = r_ring_idx;
    w_cnt_nxt      = r_cnt;
    w_start        = 1'b0;
    w_low_idx      = '0;

    for (int i = 0; i < N_ALARM; i++) begin
      if (w_wr_ok && (wr_idx == IDX_W'(i))) begin
        w_time_nxt[i]  = wr_time;
        w_armed_nxt[i] = wr_arm;
        w_snz_nxt[i]   = 1'b0;
        w_pend_nxt[i]  = 1'b0;
      end
    end

    // IDLE arbitrates on this cycle's matches too, so ring rises together with the pending bit.
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (w_pend_nxt[i]) w_low_idx = IDX_W'(i);
    end

    if (!master_en) begin
      w_pend_nxt  = '0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_pend_nxt) begin
            w_state_nxt    = S_RING;
            w_ring_idx_nxt = w_low_idx;
            w_cnt_nxt      = '0;
          end
        end
        S_RING: begin
          if (w_hit_ring) begin
            w_state_nxt = S_IDLE;
          end else if (btn_enter) begin
            w_state_nxt = S_GAME;
            w_start     = 1'b1;
          end else if (btn_snooze) begin
            w_snz_time_nxt[r_ring_idx] = w_snz_val;
            w_snz_nxt[r_ring_idx]      = 1'b1;
            w_pend_nxt[r_ring_idx]     = 1'b0;
            w_state_nxt                = S_IDLE;
          end else if (tick_1s) begin
            if ((r_cnt + 8'd1) == 8'(RING_TIMEOUT_S)) begin
              w_pend_nxt[r_ring_idx] = 1'b0;
              w_snz_nxt[r_ring_idx]  = 1'b0;
              w_state_nxt            = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        S_GAME: begin
          if (w_hit_ring) begin
            w_state_nxt = S_IDLE;
          end else if (game_done) begin
            w_pend_nxt[r_ring_idx] = 1'b0;
            w_snz_nxt[r_ring_idx]  = 1'b0;
            w_state_nxt            = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int i = 0; i < N_ALARM; i++) begin
        r_time[i]     <= '0;
        r_snz_time[i] <= '0;
      end
      r_armed      <= '0;
      r_snoozed    <= '0;
      r_pending    <= '0;
      r_state      <= S_IDLE;
      r_ring_idx   <= '0;
      r_cnt        <= '0;
      r_ring       <= 1'b0;
      r_game_en    <= 1'b0;
      r_game_start <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_time       <= w_time_nxt;
      r_snz_time   <= w_snz_time_nxt;
      r_armed      <= w_armed_nxt;
      r_snoozed    <= w_snz_nxt;
      r_pending    <= w_pend_nxt;
      r_state      <= w_state_nxt;
      r_ring_idx   <= w_ring_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ring       <= (w_state_nxt == S_RING);
      r_game_en    <= (w_state_nxt == S_GAME);
      r_game_start <= w_start;
      r_wr_err     <= wr_en & ~w_wr_ok;
    end
  end

  assign rd_time    = w_rd_time;
  assign armed      = r_armed;
  assign pending    = r_pending;
  assign ring       = r_ring;
  assign ring_idx   = r_ring_idx;
  assign game_start = r_game_start;
  assign game_en    = r_game_en;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: directed spec scenarios then random stimulus, all checked against a rule-level model.
module tb_multi_alarm_ctrl;
  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int TMO  = 60;
  localparam int IDLE = 0;
  localparam int RING = 1;
  localparam int GAME = 2;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        tick_1s = 1'b0;
  logic [15:0] cur_time = '0;
  logic        master_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [15:0] wr_time = '0;
  logic        wr_arm = 1'b0;
  logic        btn_enter = 1'b0;
  logic        btn_snooze = 1'b0;
  logic        game_done = 1'b0;
  logic [1:0]  rd_idx = '0;
  logic [15:0] rd_time;
  logic [N-1:0] armed;
  logic [N-1:0] pending;
  logic        ring;
  logic [1:0]  ring_idx;
  logic        game_start;
  logic        game_en;
  logic        wr_err;

  multi_alarm_ctrl #(.N_ALARM(N), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_S(TMO)) dut (
    .MCLK(MCLK), .RESET(RESET), .tick_1s(tick_1s), .cur_time(cur_time), .master_en(master_en),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time), .wr_arm(wr_arm),
    .btn_enter(btn_enter), .btn_snooze(btn_snooze), .game_done(game_done),
    .rd_idx(rd_idx), .rd_time(rd_time), .armed(armed), .pending(pending), .ring(ring),
    .ring_idx(ring_idx), .game_start(game_start), .game_en(game_en), .wr_err(wr_err)
  );

  always #5 MCLK = ~MCLK;

  // Reference model state: what the controller should hold after each clock edge.
  logic [15:0]  m_time [N];
  logic [15:0]  m_snzt [N];
  logic [N-1:0] m_arm, m_snz, m_pend;
  int           m_mode;
  int           m_ticks_rung;
  logic [1:0]   m_idx;
  logic         m_start, m_wrerr;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  function automatic logic [15:0] bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic valid_time(input logic [15:0] t);
    return (t[15:12] < 4'd6) && (t[11:8] < 4'd10) && (t[7:4] < 4'd6) && (t[3:0] < 4'd10);
  endfunction

  function automatic logic [15:0] pool_time(input int k);
    case (k)
      0: return 16'h0000;
      1: return 16'h0005;
      2: return 16'h0010;
      3: return 16'h5830;
      4: return 16'h0330;
      5: return 16'h1000;
      6: return 16'h0505;
      default: return bcd($urandom_range(0, 59), $urandom_range(0, 59));
    endcase
  endfunction

  task automatic model_step();
    logic ok, hit;
    int   low, mm, nm;
    m_start = 1'b0;
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        m_time[i] = '0;
        m_snzt[i] = '0;
      end
      m_arm = '0; m_snz = '0; m_pend = '0;
      m_mode = IDLE; m_idx = '0; m_ticks_rung = 0; m_wrerr = 1'b0;
      return;
    end
    if (tick_1s && master_en)
      for (int i = 0; i < N; i++)
        if (m_arm[i] && ((m_snz[i] ? m_snzt[i] : m_time[i]) == cur_time)) m_pend[i] = 1'b1;
    ok      = wr_en && valid_time(wr_time);
    m_wrerr = wr_en && !ok;
    hit     = ok && (m_mode != IDLE) && (wr_idx == m_idx);
    if (ok) begin
      m_time[wr_idx] = wr_time;
      m_arm[wr_idx]  = wr_arm;
      m_snz[wr_idx]  = 1'b0;
      m_pend[wr_idx] = 1'b0;
    end
    if (!master_en) begin
      m_pend = '0;
      m_mode = IDLE;
    end else if (m_mode == IDLE) begin
      low = -1;
      for (int i = 0; i < N; i++)
        if (m_pend[i] && low < 0) low = i;
      if (low >= 0) begin
        m_mode = RING; m_idx = 2'(low); m_ticks_rung = 0;
      end
    end else if (hit) begin
      m_mode = IDLE;
    end else if (m_mode == RING) begin
      if (btn_enter) begin
        m_mode = GAME; m_start = 1'b1;
      end else if (btn_snooze) begin
        mm = int'(cur_time[15:12]) * 10 + int'(cur_time[11:8]);
        nm = (mm + SNZ) % 60;
        m_snzt[m_idx] = {4'(nm / 10), 4'(nm % 10), m_time[m_idx][7:0]};
        m_snz[m_idx]  = 1'b1;
        m_pend[m_idx] = 1'b0;
        m_mode        = IDLE;
      end else if (tick_1s) begin
        m_ticks_rung++;
        if (m_ticks_rung >= TMO) begin
          m_pend[m_idx] = 1'b0; m_snz[m_idx] = 1'b0; m_mode = IDLE;
        end
      end
    end else if (game_done) begin
      m_pend[m_idx] = 1'b0; m_snz[m_idx] = 1'b0; m_mode = IDLE;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ring",       32'(ring),       32'(m_mode == RING));
    chk("game_en",    32'(game_en),    32'(m_mode == GAME));
    chk("game_start", 32'(game_start), 32'(m_start));
    chk("wr_err",     32'(wr_err),     32'(m_wrerr));
    chk("pending",    32'(pending),    32'(m_pend));
    chk("armed",      32'(armed),      32'(m_arm));
    chk("rd_time",    32'(rd_time),    32'(m_time[rd_idx]));
    if (m_mode != IDLE) chk("ring_idx", 32'(ring_idx), 32'(m_idx));
  endtask

  task automatic step();
    @(posedge MCLK);
    model_step();
    #1;
    check_all();
    tick_1s = 1'b0; wr_en = 1'b0; btn_enter = 1'b0; btn_snooze = 1'b0; game_done = 1'b0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [15:0] t, input logic arm);
    wr_en = 1'b1; wr_idx = idx; wr_time = t; wr_arm = arm;
    step();
  endtask

  task automatic tk(input logic [15:0] t);
    cur_time = t; tick_1s = 1'b1;
    step();
  endtask

  initial begin
    RESET = 1'b1;
    step();
    step();
    chk("rst_ring_idx", 32'(ring_idx), 32'd0);
    chk("rst_pending",  32'(pending),  32'd0);
    RESET = 1'b0; master_en = 1'b1; rd_idx = 2'd0;

    wr(2'd0, 16'h0005, 1'b1);
    chk("wr_visible", 32'(rd_time), 32'h0005);
    for (int s = 1; s <= 5; s++) tk(bcd(0, s));
    chk("s0_pending", 32'(pending), 32'b0001);
    chk("s0_ring", 32'(ring), 32'd1);

    btn_enter = 1'b1; step();
    chk("enter_start", 32'(game_start), 32'd1);
    chk("enter_gen", 32'(game_en), 32'd1);
    step();
    chk("start_pulse", 32'(game_start), 32'd0);
    game_done = 1'b1; step();
    chk("done_ring", 32'(ring), 32'd0);
    chk("done_pend", 32'(pending), 32'd0);

    wr(2'd1, 16'h0010, 1'b1);
    wr(2'd2, 16'h0010, 1'b1);
    tk(bcd(0, 10));
    chk("prio_idx1", 32'(ring_idx), 32'd1);
    btn_enter = 1'b1; step();
    game_done = 1'b1; step();
    step();
    chk("next_idx2", 32'(ring_idx), 32'd2);
    chk("next_ring", 32'(ring), 32'd1);
    btn_enter = 1'b1; step();
    game_done = 1'b1; step();

    wr(2'd0, 16'h5830, 1'b1);
    tk(16'h5830);
    chk("snz_ring", 32'(ring), 32'd1);
    btn_snooze = 1'b1; step();
    chk("snz_idle", 32'(ring), 32'd0);
    tk(16'h0329);
    tk(16'h0330);
    chk("snz_wrap_ring", 32'(ring), 32'd1);
    chk("snz_wrap_idx", 32'(ring_idx), 32'd0);
    btn_enter = 1'b1; btn_snooze = 1'b1; step();
    chk("both_btn_game", 32'(game_en), 32'd1);
    game_done = 1'b1; step();

    wr(2'd3, 16'h1000, 1'b1);
    tk(16'h1000);
    chk("tmo_ring", 32'(ring_idx), 32'd3);
    for (int k = 1; k < TMO; k++) tk(bcd(10 + k / 60, k % 60));
    chk("tmo_still", 32'(ring), 32'd1);
    tk(16'h1100);
    chk("tmo_ring_off", 32'(ring), 32'd0);
    chk("tmo_pend", 32'(pending), 32'd0);

    rd_idx = 2'd0;
    wr(2'd0, 16'h6000, 1'b1);
    chk("bad_err", 32'(wr_err), 32'd1);
    chk("bad_keep", 32'(rd_time), 32'h5830);
    wr(2'd0, 16'h0A00, 1'b0);
    chk("bad_err2", 32'(wr_err), 32'd1);
    step();

    tk(16'h1000);
    btn_enter = 1'b1; step();
    master_en = 1'b0; step();
    chk("men_gen", 32'(game_en), 32'd0);
    chk("men_pend", 32'(pending), 32'd0);
    master_en = 1'b1;
    step();

    tk(16'h1000);
    wr(2'd3, 16'h1000, 1'b1);
    chk("wr_ring_idle", 32'(ring), 32'd0);
    step();

    tk(16'h1000);
    RESET = 1'b1; step();
    chk("rst_mid_ring", 32'(ring), 32'd0);
    RESET = 1'b0;
    step();

    for (int c = 0; c < 2000; c++) begin
      master_en  = ($urandom_range(0, 15) != 0);
      btn_enter  = ($urandom_range(0, 9) == 0);
      btn_snooze = ($urandom_range(0, 9) == 0);
      game_done  = ($urandom_range(0, 7) == 0);
      rd_idx     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        wr_en   = 1'b1;
        wr_idx  = 2'($urandom_range(0, 3));
        wr_arm  = ($urandom_range(0, 3) != 0);
        wr_time = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool_time($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 0) begin
        tick_1s  = 1'b1;
        cur_time = pool_time($urandom_range(0, 8));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
